pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// Parametrised hazard/forwarding controller for the in-order pipeline_CPU family.
// Sits beside the decode (rf) stage and tracks, in a shift-register scoreboard, the destination metadata
// of every in-flight instruction past decode.
// Generates forwarding selects, load-use stalls/bubbles and branch flushes for any stage count and source count.
// Also keeps saturating stall/flush performance counters.
// PARAMETERS
// NUM_STAGES  5   total pipeline stages (>=4); tracked slots DEPTH = NUM_STAGES-2 (slot 1 = EX ... DEPTH = WB)
// AW          5   register address width
// NUM_SRC     2   source operands per decoded instruction
// ZERO_REG    31  hard-wired zero register (XZR); never forwarded, never causes a hazard
// LOAD_DIST   1   a load's result is unavailable while it occupies slots 1..LOAD_DIST (1 <= LOAD_DIST < DEPTH)
// CNT_W       32  performance counter width
// SELW = $clog2(DEPTH+1)
// PORTS
// clk          in   1           clock, rising edge
// reset        in   1           asynchronous, active-low reset
// id_valid     in   1           decode stage holds a real instruction
// id_src       in   NUM_SRC*AW  source register numbers; src i = [i*AW +: AW]
// id_src_used  in   NUM_SRC     bit i set = source i is actually read
// id_dst       in   AW          destination register of decode instruction
// id_regwrite  in   1           decode instruction writes id_dst
// id_memread   in   1           decode instruction is a load
// br_taken     in   1           branch resolved taken this cycle; kill fetch and decode
// pc_stall     out  1           hold PC
// ifid_stall   out  1           hold IF/ID register
// idex_bubble  out  1           force NOP into EX this edge
// ifid_flush   out  1           clear IF/ID register
// fwd_sel      out  NUM_SRC*SELW per source: 0 = register file, k = forward from slot k
// stall_cnt    out  CNT_W       saturating count of load-use stall cycles
// flush_cnt    out  CNT_W       saturating count of flush cycles
// BEHAVIOUR
// - Reset (reset=0, async): all slots invalid, counters 0 -> all outputs 0. Mid-operation reset discards
//   in-flight metadata immediately; first cycle after release behaves as an empty pipe.
// - Slot record = {valid, dst, regwrite, memread}. Each clk edge: slot[k+1] <= slot[k]; slot[DEPTH] retires.
//   slot[1] <= decode record if id_valid & ~stall_hz & ~br_taken, else bubble (valid=0).
// - Match(i,k): id_valid & id_src_used[i] & slot[k].valid & slot[k].regwrite & slot[k].dst==src_i & src_i!=ZERO_REG.
// - fwd_sel[i] = smallest k with Match(i,k) (youngest producer wins), else 0. Combinational, same cycle.
// - stall_hz = exists i with youngest match k <= LOAD_DIST and slot[k].memread.
// - Outputs: pc_stall = ifid_stall = stall_hz & ~br_taken; idex_bubble = stall_hz | br_taken; ifid_flush = br_taken.
// - Flush beats stall: br_taken kills decode instruction, so no stall is raised; stall_cnt does not increment.
// - Stall lasts until the load reaches slot LOAD_DIST+1 (LOAD_DIST cycles for an immediately dependent use),
//   then fwd_sel points at that slot.
// - Counters: +1 per cycle of (stall_hz & ~br_taken) / br_taken respectively; saturate at all-ones, never wrap.
// - Write to ZERO_REG is tracked but never matched. Instruction with id_regwrite=0 never forwards.
// - No handshake latency: all control outputs are combinational from registered slots + current decode inputs.
// TESTING
// 1 ADD X3 in slot1, decode src0=X3 -> fwd_sel[0]=1, src1 no match -> fwd_sel[1]=0, no stall.
// 2 Same dst X3 in slot1 and slot2 -> fwd_sel=1 (youngest); only slot2 holds X3 -> fwd_sel=2.
// 3 LDUR X5 then ADD using X5 (LOAD_DIST=1) -> one cycle pc_stall=ifid_stall=idex_bubble=1, stall_cnt=1,
//   next cycle fwd_sel=2, no stall.
// 4 Producer dst=X31 in slot1, decode src=X31 -> fwd_sel=0, no stall, even if producer is a load.
// 5 Load-use hazard and br_taken in same cycle -> ifid_flush=1, idex_bubble=1, pc_stall=0, flush_cnt+1, stall_cnt unchanged.
// 6 CNT_W=4, 20 stall cycles -> stall_cnt holds 15. Assert reset mid-stream -> outputs 0 at once, fwd_sel=0 after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard-based forwarding, load-use stall and branch flush control
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int ZERO_REG   = 31,
  parameter int LOAD_DIST  = 1,
  parameter int CNT_W      = 32,
  localparam int DEPTH     = NUM_STAGES - 2,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NUM_SRC*AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]      id_src_used,
  input  logic [AW-1:0]           id_dst,
  input  logic                    id_regwrite,
  input  logic                    id_memread,
  input  logic                    br_taken,
  output logic                    pc_stall,
  output logic                    ifid_stall,
  output logic                    idex_bubble,
  output logic                    ifid_flush,
  output logic [NUM_SRC*SELW-1:0] fwd_sel,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);
  logic [DEPTH:1]         vld_q, vld_d, rw_q, rw_d, mr_q, mr_d;
  logic [DEPTH:1][AW-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                   stall_hz, hz;
  logic [AW-1:0]          src;
  // per source, scan oldest to youngest so the youngest producer is the last one written
  always_comb begin
    stall_hz = 1'b0;
    fwd_sel = '0;
    src = '0;
    hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = id_src[i*AW +: AW];
      hz = 1'b0;
      for (int k = DEPTH; k >= 1; k--)
        if (id_valid && id_src_used[i] && vld_q[k] && rw_q[k] && dst_q[k] == src && src != AW'(ZERO_REG)) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k);
          hz = (k <= LOAD_DIST) && mr_q[k];
        end
      stall_hz = stall_hz | hz;
    end
  end
  assign pc_stall    = stall_hz & ~br_taken;
  assign ifid_stall  = pc_stall;
  assign idex_bubble = stall_hz | br_taken;
  assign ifid_flush  = br_taken;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  // shift the scoreboard one slot; decode enters slot 1 unless stalled or killed
  always_comb begin
    vld_d = {vld_q[DEPTH-1:1], id_valid & ~stall_hz & ~br_taken};
    rw_d  = {rw_q[DEPTH-1:1], id_regwrite};
    mr_d  = {mr_q[DEPTH-1:1], id_memread};
    dst_d = {dst_q[DEPTH-1:1], id_dst};
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall & ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + CNT_W'(br_taken & ~&flush_cnt_q);
  end
  // state registers; reset empties the pipe and clears the counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      rw_q <= '0;
      mr_q <= '0;
      dst_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rw_q <= rw_d;
      mr_q <= mr_d;
      dst_q <= dst_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors checked against a history-queue model every cycle
module tb_pipeline_hazard_ctrl;
  logic       clk, reset, id_valid, id_regwrite, id_memread, br_taken;
  logic [9:0] id_src;
  logic [1:0] id_src_used;
  logic [4:0] id_dst;
  logic       pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic [3:0] fwd_sel, stall_cnt, flush_cnt;
  int total = 0, fails = 0;
  int sc = 0, fc = 0;
  typedef struct {logic v; logic [4:0] d; logic rw; logic mr;} rec_t;
  rec_t hist[$];

  pipeline_hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread), .br_taken(br_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // hist[0] is the most recently issued instruction (age 1 = EX), up to 3 kept
  function automatic void model(output logic [3:0] sel, output logic hz);
    logic [4:0] s;
    sel = '0;
    hz = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = id_src[i*5 +: 5];
      if (!(id_valid && id_src_used[i]) || s == 5'd31) continue;
      for (int k = 0; k < hist.size(); k++)
        if (hist[k].v && hist[k].rw && hist[k].d == s) begin
          sel[i*2 +: 2] = 2'(k + 1);
          if (hist[k].mr && k + 1 <= 1) hz = 1'b1;
          break;
        end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [3:0] sel;
    logic hz;
    rec_t r;
    if (!reset) begin
      hist.delete();
      sc = 0;
      fc = 0;
    end else begin
      model(sel, hz);
      r.v = id_valid && !hz && !br_taken;
      r.d = id_dst;
      r.rw = id_regwrite;
      r.mr = id_memread;
      hist.push_front(r);
      if (hist.size() > 3) void'(hist.pop_back());
      if (hz && !br_taken && sc < 15) sc++;
      if (br_taken && fc < 15) fc++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] sel;
    logic hz;
    model(sel, hz);
    chk("fwd_sel", 32'(fwd_sel), 32'(sel));
    chk("pc_stall", 32'(pc_stall), 32'(hz & ~br_taken));
    chk("ifid_stall", 32'(ifid_stall), 32'(hz & ~br_taken));
    chk("idex_bubble", 32'(idex_bubble), 32'(hz | br_taken));
    chk("ifid_flush", 32'(ifid_flush), 32'(br_taken));
    chk("stall_cnt", 32'(stall_cnt), 32'(sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(fc));
  end

  task automatic drv(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] u,
                     input logic [4:0] d, input logic rw, input logic mr, input logic br);
    @(posedge clk);
    #1;
    id_valid = v; id_src = {s1, s0}; id_src_used = u; id_dst = d;
    id_regwrite = rw; id_memread = mr; br_taken = br;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] regs [3];
    regs[0] = 5'd3; regs[1] = 5'd5; regs[2] = 5'd31;
    reset = 1'b0;
    id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0;
    id_regwrite = 0; id_memread = 0; br_taken = 0;
    mid();
    chk("rst_outputs", 32'({pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_sel, stall_cnt, flush_cnt}), 0);
    reset = 1'b1;
    drv(1, 0, 0, 2'b00, 3, 1, 0, 0);
    drv(1, 3, 7, 2'b11, 3, 1, 0, 0);
    mid(); chk("t1_fwd", 32'(fwd_sel), 32'h1); chk("t1_stall", 32'(pc_stall), 0);
    drv(1, 3, 0, 2'b01, 9, 1, 0, 0);
    mid(); chk("t2_youngest", 32'(fwd_sel), 32'h1);
    drv(1, 0, 3, 2'b10, 10, 1, 0, 0);
    mid(); chk("t2_slot2", 32'(fwd_sel), 32'h8);
    drv(1, 0, 0, 2'b00, 5, 1, 1, 0);
    drv(1, 5, 0, 2'b01, 6, 1, 0, 0);
    mid(); chk("t3_stall", 32'({pc_stall, ifid_stall, idex_bubble}), 32'h7); chk("t3_cnt0", 32'(stall_cnt), 0);
    drv(1, 5, 0, 2'b01, 6, 1, 0, 0);
    mid(); chk("t3_fwd2", 32'(fwd_sel), 32'h2); chk("t3_nostall", 32'(pc_stall), 0);
    chk("t3_cnt1", 32'(stall_cnt), 1);
    drv(1, 0, 0, 2'b00, 31, 1, 1, 0);
    drv(1, 31, 0, 2'b01, 12, 1, 0, 0);
    mid(); chk("t4_zero_fwd", 32'(fwd_sel), 0); chk("t4_zero_stall", 32'(idex_bubble), 0);
    drv(1, 0, 0, 2'b00, 5, 1, 1, 0);
    drv(1, 5, 0, 2'b01, 6, 1, 0, 1);
    mid(); chk("t5_flush", 32'({ifid_flush, idex_bubble, pc_stall, ifid_stall}), 32'hc);
    drv(0, 0, 0, 2'b00, 0, 0, 0, 0);
    mid(); chk("t5_flush_cnt", 32'(flush_cnt), 1); chk("t5_stall_cnt", 32'(stall_cnt), 1);
    drv(1, 0, 0, 2'b00, 7, 0, 0, 0);
    drv(1, 7, 0, 2'b01, 8, 1, 0, 0);
    mid(); chk("nowrite_fwd", 32'(fwd_sel), 0);
    drv(1, 5, 0, 2'b01, 5, 1, 1, 0);
    repeat (44) @(posedge clk);
    mid(); chk("t6_saturate", 32'(stall_cnt), 32'hf);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("t6_async_rst", 32'({pc_stall, ifid_stall, idex_bubble, fwd_sel, stall_cnt, flush_cnt}), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    mid(); chk("t6_post_rst_fwd", 32'(fwd_sel), 0); chk("t6_post_rst_stall", 32'(pc_stall), 0);
    for (int n = 0; n < 40; n++)
      drv(1, regs[$urandom_range(0, 2)], regs[$urandom_range(0, 2)], 2'($urandom_range(0, 3)),
          regs[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 5) == 0);
    mid();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
